// File: rtl/bkm_steps_stim_if.sv
// Start/done handshake and operand bus between the bkm_steps stimulus sequencer and the DUT.
// The sequencer is the master: it issues operands and start, and the DUT answers with done.
interface bkm_steps_stim_if #(
  parameter int WD = 64
);
  logic          tb_start;
  logic          tb_mode;
  logic [1:0]    tb_format;
  logic [WD-1:0] tb_u_in;
  logic [WD-1:0] tb_v_in;
  logic          res_done;

  modport master (
    output tb_start, tb_mode, tb_format, tb_u_in, tb_v_in,
    input  res_done
  );

  modport slave (
    input  tb_start, tb_mode, tb_format, tb_u_in, tb_v_in,
    output res_done
  );
endinterface

// File: rtl/bkm_steps_stim.sv
// Stimulus sequencer for bkm_steps: loads LFSR operands, pulses start, waits for done
// with a timeout, then idles for GAP cycles before the next vector until NVEC are issued.
module bkm_steps_stim #(
  parameter int          WD      = 64,
  parameter int          NVEC    = 256,
  parameter int          TIMEOUT = 128,
  parameter int          GAP     = 2,
  parameter logic [31:0] SEED    = 32'hACE10001
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               srst,
  input  logic               enable,
  input  logic               run,
  input  logic               cfg_mode,
  input  logic [1:0]         cfg_format,
  input  logic               cfg_sweep,
  bkm_steps_stim_if.master   dut,
  output logic [15:0]        vec_cnt,
  output logic               busy,
  output logic               finished,
  output logic               timeout_err
);

  localparam int unsigned K      = WD / 32;
  localparam int unsigned NBEAT  = 2 * K;
  localparam int unsigned BW     = $clog2(NBEAT);
  localparam logic [31:0] TAPS   = 32'h80200003;
  localparam logic [15:0] NVEC16 = 16'(NVEC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_GAP,
    S_FINISH
  } state_t;

  state_t        state, state_nx;
  logic [BW-1:0] beat;
  logic [15:0]   timer;
  logic [7:0]    gap_cnt;
  logic [31:0]   lfsr, lfsr_nx;
  logic [WD-1:0] u_q, v_q;
  logic          mode_q;
  logic [1:0]    fmt_q;
  logic [15:0]   vec_inc;
  logic          load_last, gap_last, wait_end;

  assign lfsr_nx   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : '0);
  assign load_last = (beat == BW'(NBEAT - 1));
  assign gap_last  = (gap_cnt == 8'(GAP - 1));
  // A done in the final timer cycle still counts as a completion, not a timeout.
  assign wait_end  = dut.res_done || (timer == 16'(TIMEOUT - 1));
  assign vec_inc   = (vec_cnt == NVEC16) ? vec_cnt : vec_cnt + 16'd1;

  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      state <= S_IDLE;
    else if (srst)
      state <= S_IDLE;
    else if (enable)
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (run) state_nx = S_LOAD;
      S_LOAD:   if (load_last) state_nx = S_START;
      S_START:  state_nx = S_WAIT;
      S_WAIT: begin
        if (wait_end) begin
          if (GAP == 0)
            state_nx = (vec_inc < NVEC16) ? S_LOAD : S_FINISH;
          else
            state_nx = S_GAP;
        end
      end
      S_GAP:    if (gap_last) state_nx = (vec_cnt < NVEC16) ? S_LOAD : S_FINISH;
      S_FINISH: if (!run) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      beat        <= '0;
      timer       <= '0;
      gap_cnt     <= '0;
      lfsr        <= SEED;
      u_q         <= '0;
      v_q         <= '0;
      mode_q      <= 1'b0;
      fmt_q       <= '0;
      vec_cnt     <= '0;
      timeout_err <= 1'b0;
    end else if (srst) begin
      beat        <= '0;
      timer       <= '0;
      gap_cnt     <= '0;
      lfsr        <= SEED;
      u_q         <= '0;
      v_q         <= '0;
      mode_q      <= 1'b0;
      fmt_q       <= '0;
      vec_cnt     <= '0;
      timeout_err <= 1'b0;
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          if (run) begin
            vec_cnt     <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_LOAD: begin
          // Beats 0..K-1 fill u word by word, beats K..2K-1 fill v.
          for (int unsigned i = 0; i < K; i++) begin
            if (beat == BW'(i))     u_q[32*i +: 32] <= lfsr;
            if (beat == BW'(K + i)) v_q[32*i +: 32] <= lfsr;
          end
          lfsr <= lfsr_nx;
          beat <= load_last ? '0 : beat + 1'b1;
          if (load_last) begin
            mode_q <= cfg_sweep ? vec_cnt[0]   : cfg_mode;
            fmt_q  <= cfg_sweep ? vec_cnt[2:1] : cfg_format;
          end
        end
        S_START: timer <= '0;
        S_WAIT: begin
          timer   <= timer + 16'd1;
          gap_cnt <= '0;
          if (wait_end) begin
            vec_cnt <= vec_inc;
            if (!dut.res_done) timeout_err <= 1'b1;
          end
        end
        S_GAP:   gap_cnt <= gap_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  assign dut.tb_start  = (state == S_START);
  assign dut.tb_mode   = mode_q;
  assign dut.tb_format = fmt_q;
  assign dut.tb_u_in   = u_q;
  assign dut.tb_v_in   = v_q;
  assign busy          = state inside {S_LOAD, S_START, S_WAIT, S_GAP};
  assign finished      = (state == S_FINISH);

endmodule
